// File: rtl/bp_cce_alu_issue.sv
// Issue/writeback controller for the CCE ALU: one instruction in flight,
// operands read from a local GPR file, result written back and returned over valid/yumi.

package bp_cce_alu_issue_pkg;
  typedef enum logic [3:0] {
    e_add_op  = 4'd0,
    e_sub_op  = 4'd1,
    e_lsh_op  = 4'd2,
    e_rsh_op  = 4'd3,
    e_and_op  = 4'd4,
    e_or_op   = 4'd5,
    e_xor_op  = 4'd6,
    e_neg_op  = 4'd7,
    e_not_op  = 4'd8,
    e_nand_op = 4'd9,
    e_nor_op  = 4'd10,
    e_inc_op  = 4'd11,
    e_dec_op  = 4'd12
  } bp_cce_inst_minor_alu_op_e;
endpackage

module bp_cce_alu_issue
  import bp_cce_alu_issue_pkg::*;
#(
  parameter int width_p   = 16,
  parameter int num_gpr_p = 8,
  localparam int gpr_addr_width_lp = (num_gpr_p > 1) ? $clog2(num_gpr_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             inst_v_i,
  output logic                             inst_ready_o,
  input  bp_cce_inst_minor_alu_op_e        inst_op_i,
  input  logic [gpr_addr_width_lp-1:0]     inst_dst_i,
  input  logic [gpr_addr_width_lp-1:0]     inst_src_a_i,
  input  logic [gpr_addr_width_lp-1:0]     inst_src_b_i,
  input  logic                             inst_imm_sel_i,
  input  logic [width_p-1:0]               inst_imm_i,
  output logic [width_p-1:0]               alu_opd_a_o,
  output logic [width_p-1:0]               alu_opd_b_o,
  output bp_cce_inst_minor_alu_op_e        alu_op_o,
  input  logic [width_p-1:0]               alu_res_i,
  output logic                             resp_v_o,
  input  logic                             resp_yumi_i,
  output logic [width_p-1:0]               resp_res_o,
  output logic [gpr_addr_width_lp-1:0]     resp_dst_o,
  output logic                             resp_zero_o,
  input  logic [gpr_addr_width_lp-1:0]     gpr_r_addr_i,
  output logic [width_p-1:0]               gpr_r_data_o
);

  typedef enum logic [1:0] {e_ready, e_exec, e_resp} state_e;

  state_e                          state_q, state_d;
  bp_cce_inst_minor_alu_op_e       op_q, op_d, alu_op_q, alu_op_d;
  logic [gpr_addr_width_lp-1:0]    dst_q, dst_d, src_a_q, src_a_d, src_b_q, src_b_d;
  logic                            imm_sel_q, imm_sel_d;
  logic [width_p-1:0]              imm_q, imm_d;
  logic [width_p-1:0]              opd_a_q, opd_a_d, opd_b_q, opd_b_d;
  logic [width_p-1:0]              resp_res_q, resp_res_d;
  logic [gpr_addr_width_lp-1:0]    resp_dst_q, resp_dst_d;
  logic                            resp_zero_q, resp_zero_d;
  logic [width_p-1:0]              gpr_q [num_gpr_p];
  logic [width_p-1:0]              gpr_d [num_gpr_p];

  logic                            accept, in_exec;
  logic [width_p-1:0]              exec_opd_a, exec_opd_b;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_ready;
      op_q        <= e_add_op;
      alu_op_q    <= e_add_op;
      dst_q       <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      imm_sel_q   <= 1'b0;
      imm_q       <= '0;
      opd_a_q     <= '0;
      opd_b_q     <= '0;
      resp_res_q  <= '0;
      resp_dst_q  <= '0;
      resp_zero_q <= 1'b0;
      for (int i = 0; i < num_gpr_p; i++) gpr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      alu_op_q    <= alu_op_d;
      dst_q       <= dst_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      imm_sel_q   <= imm_sel_d;
      imm_q       <= imm_d;
      opd_a_q     <= opd_a_d;
      opd_b_q     <= opd_b_d;
      resp_res_q  <= resp_res_d;
      resp_dst_q  <= resp_dst_d;
      resp_zero_q <= resp_zero_d;
      gpr_q       <= gpr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      e_ready: if (inst_v_i) state_d = e_exec;
      e_exec:  state_d = e_resp;
      e_resp:  if (resp_yumi_i) state_d = e_ready;
      default: state_d = e_ready;
    endcase
  end

  // Operands are read from the GPRs during EXEC, ahead of the write at the EXEC edge.
  always_comb begin
    accept     = (state_q == e_ready) && inst_v_i;
    exec_opd_a = gpr_q[src_a_q];
    exec_opd_b = imm_sel_q ? imm_q : gpr_q[src_b_q];

    op_d        = op_q;
    dst_d       = dst_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    imm_sel_d   = imm_sel_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    opd_a_d     = opd_a_q;
    opd_b_d     = opd_b_q;
    resp_res_d  = resp_res_q;
    resp_dst_d  = resp_dst_q;
    resp_zero_d = resp_zero_q;
    gpr_d       = gpr_q;

    if (accept) begin
      op_d      = inst_op_i;
      dst_d     = inst_dst_i;
      src_a_d   = inst_src_a_i;
      src_b_d   = inst_src_b_i;
      imm_sel_d = inst_imm_sel_i;
      imm_d     = inst_imm_i;
    end

    if (state_q == e_exec) begin
      alu_op_d       = op_q;
      opd_a_d        = exec_opd_a;
      opd_b_d        = exec_opd_b;
      resp_res_d     = alu_res_i;
      resp_dst_d     = dst_q;
      resp_zero_d    = (alu_res_i == '0);
      gpr_d[dst_q]   = alu_res_i;
    end
  end

  // Outputs read as their reset values for the whole time reset_i is high.
  always_comb begin
    in_exec      = (state_q == e_exec) && !reset_i;
    inst_ready_o = (state_q == e_ready) && !reset_i;
    resp_v_o     = (state_q == e_resp) && !reset_i;
    alu_op_o     = reset_i ? e_add_op : (in_exec ? op_q : alu_op_q);
    alu_opd_a_o  = reset_i ? '0 : (in_exec ? exec_opd_a : opd_a_q);
    alu_opd_b_o  = reset_i ? '0 : (in_exec ? exec_opd_b : opd_b_q);
    resp_res_o   = reset_i ? '0 : resp_res_q;
    resp_dst_o   = reset_i ? '0 : resp_dst_q;
    resp_zero_o  = reset_i ? 1'b0 : resp_zero_q;
    gpr_r_data_o = gpr_q[gpr_r_addr_i];
  end

  yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(resp_yumi_i && !resp_v_o))
    else $error("resp_yumi_i asserted without resp_v_o");

  if (num_gpr_p != (1 << gpr_addr_width_lp)) begin : g_addr_chk
    gpr_addr_range: assert property (@(posedge clk_i) disable iff (reset_i)
      (int'(gpr_r_addr_i) < num_gpr_p) &&
      (!inst_v_i || ((int'(inst_dst_i) < num_gpr_p) && (int'(inst_src_a_i) < num_gpr_p) &&
                     (int'(inst_src_b_i) < num_gpr_p))))
      else $error("GPR address out of range");
  end

endmodule

// File: tb/tb_bp_cce_alu_issue.sv
// Directed bench for bp_cce_alu_issue with a behavioural ALU and a response scoreboard.

module tb_bp_cce_alu_issue;
  import bp_cce_alu_issue_pkg::*;

  localparam int W  = 16;
  localparam int NG = 8;
  localparam int AW = 3;

  logic                       clk = 1'b0;
  logic                       reset_i = 1'b1;
  logic                       inst_v_i = 1'b0;
  logic                       inst_ready_o;
  bp_cce_inst_minor_alu_op_e  inst_op_i = e_add_op;
  logic [AW-1:0]              inst_dst_i = '0, inst_src_a_i = '0, inst_src_b_i = '0;
  logic                       inst_imm_sel_i = 1'b0;
  logic [W-1:0]               inst_imm_i = '0;
  logic [W-1:0]               alu_opd_a_o, alu_opd_b_o, alu_res_i;
  bp_cce_inst_minor_alu_op_e  alu_op_o;
  logic                       resp_v_o;
  logic                       resp_yumi_i = 1'b0;
  logic [W-1:0]               resp_res_o;
  logic [AW-1:0]              resp_dst_o;
  logic                       resp_zero_o;
  logic [AW-1:0]              gpr_r_addr_i = '0;
  logic [W-1:0]               gpr_r_data_o;

  bp_cce_alu_issue #(.width_p(W), .num_gpr_p(NG)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .inst_v_i(inst_v_i), .inst_ready_o(inst_ready_o),
    .inst_op_i(inst_op_i), .inst_dst_i(inst_dst_i),
    .inst_src_a_i(inst_src_a_i), .inst_src_b_i(inst_src_b_i),
    .inst_imm_sel_i(inst_imm_sel_i), .inst_imm_i(inst_imm_i),
    .alu_opd_a_o(alu_opd_a_o), .alu_opd_b_o(alu_opd_b_o), .alu_op_o(alu_op_o),
    .alu_res_i(alu_res_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .resp_res_o(resp_res_o), .resp_dst_o(resp_dst_o), .resp_zero_o(resp_zero_o),
    .gpr_r_addr_i(gpr_r_addr_i), .gpr_r_data_o(gpr_r_data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input bp_cce_inst_minor_alu_op_e op,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      e_add_op: return a + b;
      e_sub_op: return a - b;
      e_and_op: return a & b;
      e_or_op:  return a | b;
      e_xor_op: return a ^ b;
      e_neg_op: return ~a;
      default:  return a + b;
    endcase
  endfunction

  always_comb alu_res_i = alu_f(alu_op_o, alu_opd_a_o, alu_opd_b_o);

  typedef struct {
    logic [AW-1:0] dst;
    logic [W-1:0]  res;
  } exp_t;

  exp_t          exp_q[$];
  logic [W-1:0]  gm [NG];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bp_cce_inst_minor_alu_op_e op, input logic [AW-1:0] dst,
                       input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                       input logic isel, input logic [W-1:0] imm, input logic [W-1:0] exp_res);
    logic [W-1:0] ea, eb;
    exp_t         e;
    int           n;
    @(negedge clk);
    ea = gm[sa];
    eb = isel ? imm : gm[sb];
    inst_v_i = 1'b1; inst_op_i = op; inst_dst_i = dst; inst_src_a_i = sa;
    inst_src_b_i = sb; inst_imm_sel_i = isel; inst_imm_i = imm;
    exp_q.push_back('{dst: dst, res: exp_res});
    #1 chk("inst_ready_accept", inst_ready_o, 1);
    @(negedge clk);
    inst_v_i = 1'b0;
    chk("exec_opd_a", alu_opd_a_o, ea);
    chk("exec_opd_b", alu_opd_b_o, eb);
    chk("exec_op", alu_op_o, op);
    chk("exec_ready_low", inst_ready_o, 0);
    n = 0;
    @(negedge clk);
    while (!resp_v_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("resp_latency", n, 0);
    e = exp_q.pop_front();
    if (resp_v_o) begin
      chk("resp_res", resp_res_o, e.res);
      chk("resp_dst", resp_dst_o, e.dst);
      chk("resp_zero", resp_zero_o, (e.res == '0));
      gpr_r_addr_i = e.dst;
      #1 chk("gpr_writeback", gpr_r_data_o, e.res);
    end
    gm[dst] = exp_res;
  endtask

  task automatic consume(input int hold);
    logic [W-1:0]  r;
    logic [AW-1:0] d;
    logic          z;
    r = resp_res_o; d = resp_dst_o; z = resp_zero_o;
    if (hold > 0) begin
      inst_v_i = 1'b1; inst_op_i = e_add_op; inst_dst_i = 3'd7; inst_src_a_i = 3'd0;
      inst_imm_sel_i = 1'b1; inst_imm_i = 16'hBEEF;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_resp_v", resp_v_o, 1);
      chk("hold_resp_res", resp_res_o, r);
      chk("hold_resp_dst", resp_dst_o, d);
      chk("hold_resp_zero", resp_zero_o, z);
      chk("hold_ready_low", inst_ready_o, 0);
    end
    resp_yumi_i = 1'b1;
    @(negedge clk);
    resp_yumi_i = 1'b0;
    inst_v_i = 1'b0;
    chk("post_yumi_resp_v", resp_v_o, 0);
    chk("post_yumi_ready", inst_ready_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NG; i++) gm[i] = '0;

    // Reset behaviour
    repeat (2) @(negedge clk);
    chk("rst_ready", inst_ready_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_alu_op", alu_op_o, e_add_op);
    chk("rst_opd_a", alu_opd_a_o, 0);
    chk("rst_opd_b", alu_opd_b_o, 0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", inst_ready_o, 1);
    chk("post_rst_resp_v", resp_v_o, 0);
    for (int i = 0; i < NG; i++) begin
      gpr_r_addr_i = AW'(i);
      #1 chk("rst_gpr", gpr_r_data_o, 0);
    end

    // Immediate add
    issue(e_add_op, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0005, 16'h0005);
    consume(0);

    // Wrap-around and zero flag
    issue(e_sub_op, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0006, 16'hFFFF);
    consume(0);
    issue(e_add_op, 3'd2, 3'd2, 3'd0, 1'b1, 16'h0001, 16'h0000);
    consume(0);

    // Backpressure with a competing instruction offered throughout
    issue(e_add_op, 3'd6, 3'd1, 3'd0, 1'b1, 16'h1230, 16'h1235);
    consume(5);
    gpr_r_addr_i = 3'd7;
    #1 chk("no_spurious_accept", gpr_r_data_o, 0);

    // Register-register
    issue(e_add_op, 3'd5, 3'd1, 3'd6, 1'b0, 16'h0000, 16'h123A);
    consume(0);

    // Aliasing and neg
    issue(e_or_op, 3'd3, 3'd0, 3'd0, 1'b1, 16'h00F0, 16'h00F0);
    consume(0);
    issue(e_xor_op, 3'd3, 3'd3, 3'd3, 1'b0, 16'h0000, 16'h0000);
    consume(0);
    issue(e_neg_op, 3'd4, 3'd3, 3'd0, 1'b1, 16'h0055, 16'hFFFF);
    consume(0);

    // Reset asserted in the EXEC cycle
    @(negedge clk);
    inst_v_i = 1'b1; inst_op_i = e_add_op; inst_dst_i = 3'd5; inst_src_a_i = 3'd0;
    inst_imm_sel_i = 1'b1; inst_imm_i = 16'h0007;
    @(negedge clk);
    inst_v_i = 1'b0;
    reset_i = 1'b1;
    #1 chk("mid_rst_opd_b", alu_opd_b_o, 0);
    chk("mid_rst_resp_v", resp_v_o, 0);
    @(negedge clk);
    chk("mid_rst_resp_v2", resp_v_o, 0);
    chk("mid_rst_ready", inst_ready_o, 0);
    reset_i = 1'b0;
    for (int i = 0; i < NG; i++) gm[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_resp_v", resp_v_o, 0);
      chk("after_rst_ready", inst_ready_o, 1);
    end
    gpr_r_addr_i = 3'd5;
    #1 chk("after_rst_gpr5", gpr_r_data_o, 0);
    gpr_r_addr_i = 3'd1;
    #1 chk("after_rst_gpr1", gpr_r_data_o, 0);

    // Works normally again after the aborted instruction
    issue(e_add_op, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0007, 16'h0007);
    consume(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_cce_alu_issue.md
Name: bp_cce_alu_issue

Overview:
Sequential issue and writeback controller that drives the CCE ALU.
- Accepts one ALU microcode instruction at a time over a valid/ready handshake.
- Reads source operands from an internal GPR file and presents operands plus op to the external combinational ALU.
- Captures the ALU result, writes it back to the destination GPR, and returns a response over a valid/yumi handshake.
- Sits between CCE instruction decode and the ALU.

Parameters:
width_p, "inv", GPR and ALU operand width in bits
num_gpr_p, 8, number of GPRs; gpr_addr_width = $clog2(num_gpr_p)

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
inst_v_i  input  1  instruction valid
inst_ready_o  output  1  controller can accept an instruction
inst_op_i  input  bp_cce_inst_minor_alu_op_e  ALU operation
inst_dst_i  input  gpr_addr_width  destination GPR
inst_src_a_i  input  gpr_addr_width  operand A GPR
inst_src_b_i  input  gpr_addr_width  operand B GPR
inst_imm_sel_i  input  1  1: operand B is inst_imm_i; 0: operand B is GPR[src_b]
inst_imm_i  input  width_p  immediate
alu_opd_a_o  output  width_p  operand A to ALU
alu_opd_b_o  output  width_p  operand B to ALU
alu_op_o  output  bp_cce_inst_minor_alu_op_e  op to ALU
alu_res_i  input  width_p  ALU result (combinational from alu_*_o)
resp_v_o  output  1  response valid
resp_yumi_i  input  1  response consumed; legal only when resp_v_o=1
resp_res_o  output  width_p  result written back
resp_dst_o  output  gpr_addr_width  GPR that was written
resp_zero_o  output  1  result == 0
gpr_r_addr_i  input  gpr_addr_width  debug GPR read address
gpr_r_data_o  output  width_p  GPR[gpr_r_addr_i], combinational

Behaviour:
- Reset, synchronous while reset_i=1:
  - All GPRs = 0.
  - State = READY.
  - inst_ready_o = 0, resp_v_o = 0.
  - resp_res_o, resp_dst_o, resp_zero_o = 0.
  - alu_op_o = e_add_op; alu_opd_a_o, alu_opd_b_o = 0.
- Reset mid-operation (EXEC or RESP) aborts the instruction. No GPR write occurs if reset_i=1 in the EXEC cycle.
- FSM states are READY, EXEC and RESP. Only one instruction is in flight at a time.
- READY:
  - inst_ready_o = 1 (0 if reset_i=1).
  - On inst_v_i & inst_ready_o, register op, dst, src_a, src_b, imm_sel and imm, then go to EXEC.
  - inst_* values are ignored when inst_v_i=0.
- EXEC (one cycle):
  - alu_opd_a_o = GPR[src_a_r].
  - alu_opd_b_o = imm_sel_r ? imm_r : GPR[src_b_r].
  - alu_op_o = op_r.
  - At the clock edge: GPR[dst_r] <= alu_res_i; resp_res_o <= alu_res_i; resp_dst_o <= dst_r; resp_zero_o <= (alu_res_i == 0). Then go to RESP.
  - Outside EXEC, alu_opd_* and alu_op_o hold their last EXEC values (registered); the ALU result is ignored.
- RESP:
  - resp_v_o = 1. resp_* fields are held stable until resp_yumi_i.
  - On resp_yumi_i, go to READY. resp_v_o drops the next cycle.
  - inst_ready_o = 0 in EXEC and RESP. No accept occurs in the yumi cycle.
- Latency: accept at cycle N, ALU driven at N+1, resp_v_o and the updated GPR visible at N+2.
- Minimum throughput: one instruction per 3 cycles.
- Aliasing: dst == src_a == src_b is legal. Operands are read in EXEC before the write at the EXEC clock edge.
- Width: results are width_p bits. Wrap-around (overflow/underflow) is the ALU's and is passed through unchanged.
- Operand B for e_neg_op is driven per imm_sel and ignored by the ALU.
- Debug read port: reflects a write the cycle after the EXEC edge. Reads are never blocked.
- Assertions (simulation only):
  - resp_yumi_i=1 while resp_v_o=0 is an error.
  - Any address input >= num_gpr_p is an error.

Test Plan:
1. Reset, then read all GPRs -> all 0; inst_ready_o=0 during reset, 1 the cycle after reset_i falls; resp_v_o=0.
2. width_p=16, imm add: GPR1=0, issue {e_add_op, dst=1, src_a=1, imm_sel=1, imm=5} at N -> at N+1 alu_opd_a_o=0, alu_opd_b_o=5; at N+2 resp_v_o=1, resp_res_o=5, resp_dst_o=1, resp_zero_o=0, gpr_r_data_o(1)=5.
3. Wrap and zero flag: GPR1=5, issue {e_sub_op, dst=2, src_a=1, imm=6, imm_sel=1} -> resp_res_o=0xFFFF; then {e_add_op, dst=2, src_a=2, imm=1} -> resp_res_o=0, resp_zero_o=1.
4. Backpressure: hold resp_yumi_i=0 for 5 cycles -> resp_v_o and resp_* stable; inst_ready_o=0 even with inst_v_i=1 and no accept; yumi on cycle 6 -> inst_ready_o=1 the following cycle.
5. Register-register with aliasing: GPR3=0x00F0, issue {e_xor_op, dst=3, src_a=3, src_b=3, imm_sel=0} -> resp_res_o=0, GPR3=0; then {e_neg_op, dst=4, src_a=3} -> GPR4=0xFFFF.
6. Reset mid-op: accept {e_add_op, dst=5, imm=7} and assert reset_i in the EXEC cycle -> GPR5=0, resp_v_o never asserted, state READY after reset.
